// File: rtl/lfsr_pkg.sv
// Purpose: shared types, default tap mask and single-step LFSR function for the keystream block.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package lfsr_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Widest state the step function handles; states are right-aligned in this width.
    localparam int MAX_W = 64;

    // Taps {26,8,7,1}; mask bit t (numbered 1..26) selects q[t].
    localparam logic [26:1] DEFAULT_TAPS = 26'h20000C1;

    typedef struct packed {
        logic [MAX_W-1:0] q_next;
        logic             out_bit;
    } step_t;

    // One Fibonacci step. The state is right-aligned: st[width-k] holds q[k],
    // so q[width] (the output bit) sits at st[0] and q[1] at st[width-1].
    // The tap mask is right-aligned too: taps[t-1] selects q[t].
    function automatic step_t lfsr_step(input logic [MAX_W-1:0] st,
                                        input logic [MAX_W-1:0] taps,
                                        input int               width);
        step_t r;
        logic  fb;
        fb = 1'b0;
        for (int t = 1; t <= MAX_W; t++) begin
            if (t <= width && taps[t-1]) begin
                fb = fb ^ st[width-t];
            end
        end
        r.out_bit          = st[0];
        r.q_next           = st >> 1;
        r.q_next[width-1]  = fb;
        return r;
    endfunction

endpackage

// File: rtl/lfsr_step_n.sv
// Purpose: advance an LFSR state by OUT_W steps and collect the OUT_W output bits.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to register q_out.
// Ports: q_in (state [1:WIDTH]), q_out (state after OUT_W steps), word (bit i = output of step i+1).
module lfsr_step_n
    import lfsr_pkg::*;
#(
    parameter int                WIDTH = 26,
    parameter logic [WIDTH:1]    TAPS  = DEFAULT_TAPS,
    parameter int                OUT_W = 8
) (
    input  logic [1:WIDTH]   q_in,
    output logic [1:WIDTH]   q_out,
    output logic [OUT_W-1:0] word
);

    logic [MAX_W-1:0] st;
    step_t            stp;

    always_comb begin
        st   = MAX_W'(q_in);
        stp  = '0;
        word = '0;
        for (int i = 0; i < OUT_W; i++) begin
            stp     = lfsr_step(st, MAX_W'(TAPS), WIDTH);
            word[i] = stp.out_bit;
            st      = stp.q_next;
        end
        q_out = st[WIDTH-1:0];
    end

endmodule

// File: rtl/lfsr_keystream.sv
// Purpose: seeded Fibonacci LFSR keystream generator emitting OUT_W-bit beats, finite or free-running.
// Latency: out_data is combinational from q; a beat is offered the cycle after start.
// Backpressure: valid/ready; while out_valid && !out_ready both out_data and q hold.
// Ports: load/din seed the state in IDLE; start/len begin a run (len 0 = free-run); stop aborts;
//        out_data/out_valid/out_ready carry beats; q exposes the state; done/seed_err are 1-cycle pulses.
module lfsr_keystream
    import lfsr_pkg::*;
#(
    parameter int             WIDTH = 26,
    parameter logic [WIDTH:1] TAPS  = DEFAULT_TAPS,
    parameter int             OUT_W = 8,
    parameter int             LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [1:WIDTH]   din,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             stop,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:WIDTH]   q,
    output logic             done,
    output logic             seed_err
);

    state_t           state, state_nx;
    logic [LEN_W-1:0] cnt, cnt_nx;
    logic [1:WIDTH]   q_nx;
    logic [1:WIDTH]   q_adv;
    logic             accept;

    lfsr_step_n #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .OUT_W (OUT_W)
    ) u_step (
        .q_in  (q),
        .q_out (q_adv),
        .word  (out_data)
    );

    // An all-zero state is a lock-up; never offer it as keystream.
    assign out_valid = (state == ST_RUN) && (q != '0);
    assign accept    = out_valid && out_ready;

    always_comb begin
        state_nx = state;
        q_nx     = q;
        cnt_nx   = cnt;
        done     = 1'b0;
        seed_err = 1'b0;
        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        if (din != '0) q_nx = din;
                        else           seed_err = 1'b1;
                    end
                    if (start) begin
                        state_nx = ST_RUN;
                        cnt_nx   = len;
                    end
                end
                ST_RUN: begin
                    if (load) seed_err = 1'b1;
                    if (accept) begin
                        q_nx = q_adv;
                        // cnt == 0 marks free-run: no countdown, no done.
                        if (cnt != '0) begin
                            cnt_nx = cnt - 1'b1;
                            if (cnt == LEN_W'(1)) begin
                                done     = 1'b1;
                                state_nx = ST_IDLE;
                            end
                        end
                    end
                    // A beat accepted alongside stop still advances q above.
                    if (stop) state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            q     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            q     <= q_nx;
            cnt   <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_lfsr_keystream.sv
// Purpose: self-checking bench for lfsr_keystream (default 26-bit/8-bit-beat and 16-bit/1-bit-beat instances).
// Latency: checks outputs 1-2 ns after each rising edge.
// Backpressure: exercises stalls via out_ready patterns and random ready.
module tb_lfsr_keystream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        load, start, stop, out_ready;
    logic [1:26] din;
    logic [15:0] len;
    logic [7:0]  out_data;
    logic        out_valid, done, seed_err;
    logic [1:26] q;

    logic        l2, s2, sp2, or2;
    logic [1:16] d2;
    logic [15:0] ln2;
    logic [0:0]  od2;
    logic        ov2, dn2, er2;
    logic [1:16] q2;

    lfsr_keystream dut (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din), .start(start), .len(len),
        .stop(stop), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .done(done), .seed_err(seed_err)
    );

    lfsr_keystream #(.WIDTH(16), .TAPS(16'hD008), .OUT_W(1), .LEN_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .load(l2), .din(d2), .start(s2), .len(ln2),
        .stop(sp2), .out_data(od2), .out_valid(ov2), .out_ready(or2),
        .q(q2), .done(dn2), .seed_err(er2)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int T26[4] = '{26, 8, 7, 1};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        load = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        din = '0; len = '0;
    endtask

    // Reference: state held as a list of bits s[k-1] = q[k]; each step emits the
    // last bit, drops it, and pushes the XOR of the listed tap positions in front.
    function automatic logic [63:0] m_adv(input logic [63:0] v, input int w, input int tl[4],
                                          input int n, output logic [63:0] word);
        bit          s[$];
        bit          fb;
        logic [63:0] r;
        for (int k = 1; k <= w; k++) s.push_back(v[w-k]);
        word = '0;
        for (int i = 0; i < n; i++) begin
            word[i] = s[w-1];
            fb = 1'b0;
            for (int j = 0; j < 4; j++) fb = fb ^ s[tl[j]-1];
            void'(s.pop_back());
            s.push_front(fb);
        end
        r = '0;
        for (int k = 1; k <= w; k++) r[w-k] = s[k-1];
        return r;
    endfunction

    typedef struct {
        logic [63:0] seed;
        int          nbeat;
        logic [63:0] exp_w0;
        logic [63:0] exp_q1;
    } vec_t;

    vec_t        vt[6];
    logic [63:0] tq, nq, w, sd, dn;
    bit          m_run;
    int          m_rem;
    bit          e_valid, e_done, e_err, ld, st, sp, rdy;
    int          ln, acc, k, zeros;
    bit          rdy_pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        // Table: first entry carries hand-derived constants, the rest come from the model.
        vt[0] = '{64'h1, 1, 64'h01, 64'h1FC0000};
        for (int i = 1; i < 6; i++) begin
            vt[i].seed  = 64'($urandom_range(1, 32'h3FFFFFF));
            vt[i].nbeat = $urandom_range(1, 5);
            vt[i].exp_q1 = m_adv(vt[i].seed, 26, T26, 8, w);
            vt[i].exp_w0 = w;
        end

        idle_in();
        l2 = 1'b0; s2 = 1'b0; sp2 = 1'b0; or2 = 1'b0; d2 = '0; ln2 = '0;
        rst_n = 1'b0;
        tick(); tick();
        // Reset overrides inputs: a zero-seed load during reset must not flag.
        load = 1'b1; din = '0; #1;
        chk("reset_q", 64'(q), 64'h0);
        chk("reset_valid", 64'(out_valid), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_seed_err", 64'(seed_err), 64'h0);
        load = 1'b0;
        rst_n = 1'b1;
        tick();

        // Start with an all-zero state: RUN is entered but nothing is offered.
        start = 1'b1; len = '0; tick(); start = 1'b0;
        out_ready = 1'b1; #1;
        chk("zero_q_valid", 64'(out_valid), 64'h0);
        tick();
        chk("zero_q_hold", 64'(q), 64'h0);
        load = 1'b1; din = 26'h5; #1;
        chk("zero_q_in_run_err", 64'(seed_err), 64'h1);
        load = 1'b0; stop = 1'b1; tick(); stop = 1'b0; out_ready = 1'b0;

        // Zero seed rejected in IDLE.
        load = 1'b1; din = '0; #1;
        chk("zero_seed_err", 64'(seed_err), 64'h1);
        tick(); load = 1'b0; #1;
        chk("zero_seed_err_pulse", 64'(seed_err), 64'h0);
        chk("zero_seed_q", 64'(q), 64'h0);

        // Table-driven finite runs, load coincident with start.
        foreach (vt[v]) begin
            din = vt[v].seed[25:0]; load = 1'b1; start = 1'b1; len = 16'(vt[v].nbeat);
            tick();
            load = 1'b0; start = 1'b0;
            tq = vt[v].seed;
            chk("tbl_valid", 64'(out_valid), 64'h1);
            chk("tbl_w0", 64'(out_data), vt[v].exp_w0);
            for (int b = 0; b < vt[v].nbeat; b++) begin
                out_ready = 1'b1; #1;
                nq = m_adv(tq, 26, T26, 8, w);
                chk("tbl_data", 64'(out_data), w);
                chk("tbl_done", 64'(done), 64'(b == vt[v].nbeat - 1));
                tick();
                tq = nq;
                chk("tbl_q", 64'(q), (b == 0) ? vt[v].exp_q1 : tq);
            end
            out_ready = 1'b0; #1;
            chk("tbl_end_valid", 64'(out_valid), 64'h0);
        end

        // len=3 with ready pattern 1,0,1,1.
        sd = 64'($urandom_range(1, 32'h3FFFFFF));
        din = sd[25:0]; load = 1'b1; start = 1'b1; len = 16'd3; tick();
        load = 1'b0; start = 1'b0;
        tq = sd; acc = 0;
        for (int i = 0; i < 4; i++) begin
            out_ready = rdy_pat[i]; #1;
            nq = m_adv(tq, 26, T26, 8, w);
            chk("stall_valid", 64'(out_valid), 64'h1);
            chk("stall_data", 64'(out_data), w);
            chk("stall_done", 64'(done), 64'(rdy_pat[i] && acc == 2));
            tick();
            if (rdy_pat[i]) begin tq = nq; acc++; end
            chk("stall_q", 64'(q), tq);
        end
        out_ready = 1'b1; #1;
        chk("stall_idle", 64'(out_valid), 64'h0);
        tick();
        chk("stall_no_4th", 64'(q), tq);
        out_ready = 1'b0;

        // stop together with an accepted (non-final) beat.
        sd = 64'($urandom_range(1, 32'h3FFFFFF));
        din = sd[25:0]; load = 1'b1; start = 1'b1; len = 16'd5; tick();
        load = 1'b0; start = 1'b0; tq = sd;
        out_ready = 1'b1; tick();
        tq = m_adv(tq, 26, T26, 8, w);
        stop = 1'b1; #1;
        chk("stop_done", 64'(done), 64'h0);
        tick();
        tq = m_adv(tq, 26, T26, 8, w);
        stop = 1'b0;
        chk("stop_q", 64'(q), tq);
        chk("stop_valid", 64'(out_valid), 64'h0);
        out_ready = 1'b0;

        // load during RUN is rejected.
        sd = 64'($urandom_range(1, 32'h3FFFFFF));
        din = sd[25:0]; load = 1'b1; start = 1'b1; len = '0; tick();
        start = 1'b0; din = ~sd[25:0]; #1;
        chk("run_load_err", 64'(seed_err), 64'h1);
        tick(); load = 1'b0;
        chk("run_load_q", 64'(q), sd);
        chk("run_load_valid", 64'(out_valid), 64'h1);
        stop = 1'b1; tick(); stop = 1'b0;

        // Mid-run reset.
        din = sd[25:0]; load = 1'b1; start = 1'b1; len = '0; tick();
        load = 1'b0; start = 1'b0; out_ready = 1'b1; tick();
        chk("mid_valid_pre", 64'(out_valid), 64'h1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mid_rst_q", 64'(q), 64'h0);
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        load = 1'b1; din = sd[25:0]; #1;
        chk("mid_rst_idle", 64'(seed_err), 64'h0);
        tick(); load = 1'b0; out_ready = 1'b0;
        chk("mid_rst_load", 64'(q), sd);
        chk("mid_rst_idle_valid", 64'(out_valid), 64'h0);

        // Random traffic against the reference model.
        tq = sd; m_run = 1'b0; m_rem = 0;
        for (int c = 0; c < 1500; c++) begin
            ld  = ($urandom % 8) == 0;
            dn  = (($urandom % 4) == 0) ? 64'h0 : 64'($urandom & 32'h3FFFFFF);
            st  = ($urandom % 10) == 0;
            ln  = $urandom_range(0, 4);
            sp  = ($urandom % 16) == 0;
            rdy = $urandom % 2;
            load = ld; din = dn[25:0]; start = st; len = 16'(ln); stop = sp; out_ready = rdy;
            #1;
            nq      = m_adv(tq, 26, T26, 8, w);
            e_valid = m_run && tq != 0;
            e_done  = e_valid && rdy && m_rem == 1;
            e_err   = ld && (m_run || dn == 0);
            chk("rnd_valid", 64'(out_valid), 64'(e_valid));
            if (e_valid) chk("rnd_data", 64'(out_data), w);
            chk("rnd_done", 64'(done), 64'(e_done));
            chk("rnd_err", 64'(seed_err), 64'(e_err));
            if (!m_run) begin
                if (ld && dn != 0) tq = dn;
                if (st) begin m_run = 1'b1; m_rem = ln; end
            end else begin
                if (e_valid && rdy) begin
                    tq = nq;
                    if (m_rem > 0) begin
                        m_rem--;
                        if (m_rem == 0) m_run = 1'b0;
                    end
                end
                if (sp) m_run = 1'b0;
            end
            tick();
            chk("rnd_q", 64'(q), tq);
        end
        idle_in();

        // 16-bit maximal-length period, one bit per beat.
        d2 = 16'h0001; l2 = 1'b1; s2 = 1'b1; ln2 = '0; or2 = 1'b1; tick();
        l2 = 1'b0; s2 = 1'b0;
        chk("p16_valid", 64'(ov2), 64'h1);
        chk("p16_first_bit", 64'(od2), 64'h1);
        k = 0; zeros = 0;
        do begin
            tick();
            k++;
            if (q2 == '0) zeros++;
        end while (q2 != 16'h0001 && k < 70000);
        chk("p16_period", 64'(k), 64'd65535);
        chk("p16_no_zero", 64'(zeros), 64'h0);
        chk("p16_no_done", 64'(dn2), 64'h0);
        or2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_keystream.md
LFSR_KEYSTREAM -- requirements
Module: lfsr_keystream

Interface
REQ-001 Parameter WIDTH, default 26: LFSR state length in bits, legal range 4..64.
REQ-002 Parameter TAPS, default {26,8,7,1} encoded as a WIDTH-bit mask (bit t set = tap at q[t]): Fibonacci feedback taps.
REQ-003 Parameter OUT_W, default 8: keystream bits per output beat, legal range 1..WIDTH.
REQ-004 Parameter LEN_W, default 16: width of the beat-length field.
REQ-005 clk  in  1  rising-edge clock; all state changes on posedge clk.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 load  in  1  seed-load request; honoured only in IDLE.
REQ-008 din  in  WIDTH  parallel seed; bit 1 is MSB (declared [1:WIDTH]).
REQ-009 start  in  1  begin generation; sampled only in IDLE.
REQ-010 len  in  LEN_W  beats to generate, sampled with start; 0 = free-run.
REQ-011 stop  in  1  abort generation; takes effect in RUN.
REQ-012 out_data  out  OUT_W  keystream word; bit 0 is the first bit generated.
REQ-013 out_valid  out  1  out_data is valid.
REQ-014 out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
REQ-015 q  out  WIDTH  current LFSR state, [1:WIDTH].
REQ-016 done  out  1  one-cycle pulse when the last beat of a finite run is accepted.
REQ-017 seed_err  out  1  one-cycle pulse when a load is rejected.

Function
REQ-018 Single step: new = XOR of q[t] over all set TAPS bits; q <= {new, q[1:WIDTH-1]}; the step's output bit is q[WIDTH] before the step.
REQ-019 out_data bit i is the output bit of step i+1 from the current q; out_data is combinational from q; no extra latency.
REQ-020 On each accepted beat, q advances by exactly OUT_W steps in one cycle.
REQ-021 FSM has two states: IDLE (out_valid=0) and RUN (out_valid=1).
REQ-022 IDLE->RUN on start; remaining-beat counter <= len; out_valid rises the next cycle.
REQ-023 RUN->IDLE when stop is high, or when a finite run's final beat is accepted (done pulses in that same cycle).
REQ-024 If stop and an accepted beat coincide, the beat counts: q advances, then go to IDLE; done does not pulse unless the beat was the final one.
REQ-025 While out_valid && !out_ready, out_data and q hold stable.
REQ-026 In IDLE, load with din != 0 sets q <= din next cycle.
REQ-027 In IDLE, load with din == 0 is rejected: q unchanged, seed_err pulses.
REQ-028 In RUN, load is ignored and seed_err pulses.
REQ-029 If load and start coincide in IDLE, the load is applied and the FSM enters RUN; the first beat uses the new seed.
REQ-030 Free-run (len=0) never pulses done; the counter does not decrement.
REQ-031 If q reaches all-zero (unreachable with a legal nonzero seed and primitive TAPS), out_valid stays 0 until a valid load.

Reset
REQ-032 rst_n low at posedge clk: q <= 0, FSM <= IDLE, counter <= 0, out_valid=0, done=0, seed_err=0; this overrides all other inputs, including mid-run.
REQ-033 After reset, a valid load is required before any output; start with q=0 enters RUN but REQ-031 holds out_valid low.

Structure
REQ-034 Package lfsr_pkg holds the FSM state enum, the default TAPS mask constant, and a step function (q, TAPS) -> (q_next, bit).
REQ-035 One sub-module, lfsr_step_n: a combinational OUT_W-fold unroll of the step that returns the advanced state and the OUT_W-bit word.

Verification
REQ-036 Reset, load din=26'h0000001, start len=0, out_ready=1 -> first out_data=8'h01; q after that beat = 26'h1FC0000.
REQ-037 Load din=0 in IDLE -> seed_err pulses once, q unchanged; load during RUN -> seed_err pulses, q is not overwritten.
REQ-038 start len=3, out_ready toggled 1,0,1,1 -> exactly 3 beats accepted, data held while stalled, done pulses on the 3rd acceptance, then IDLE.
REQ-039 stop asserted in the same cycle as an accepted beat -> q advances by 8 steps, out_valid low next cycle, no done.
REQ-040 Assert rst_n=0 mid-run with out_valid=1 -> next cycle q=0, out_valid=0, IDLE.
REQ-041 WIDTH=16, TAPS={16,15,13,4}, OUT_W=1, free-run from seed 16'h0001 -> period 65535 beats, state never 0.
